// File: rtl/pwm_regs_pkg.sv
// PWM register map, legal word-write bases and sequencer state encoding.
// Shared by pwm_cfg_sequencer and its testbench.
package pwm_regs_pkg;

  localparam logic [7:0] PERIOD_L      = 8'h00;
  localparam logic [7:0] PERIOD_H      = 8'h01;
  localparam logic [7:0] COMPARE1_L    = 8'h03;
  localparam logic [7:0] COMPARE1_H    = 8'h04;
  localparam logic [7:0] COMPARE2_L    = 8'h05;
  localparam logic [7:0] COMPARE2_H    = 8'h06;
  localparam logic [7:0] COUNTER_VAL_L = 8'h08;
  localparam logic [7:0] COUNTER_VAL_H = 8'h09;
  localparam logic [7:0] FUNCTIONS     = 8'h0D;

  localparam int N_WORD_BASE = 3;

  localparam logic [7:0] WORD_BASE [N_WORD_BASE] =
    '{PERIOD_L, COMPARE1_L, COMPARE2_L};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST,
    ST_WORD_L,
    ST_WORD_H,
    ST_DONE
  } seq_state_e;

  function automatic logic is_word_base(
    input logic [31:0] a
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_WORD_BASE; i++) begin
      if (a == {24'h0, WORD_BASE[i]}) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/pwm_cfg_sequencer_rr_arb2.sv
// Two-requester round-robin arbiter, registered last-grant pointer.
// Ports: clk, rst_n (sync, low), req[1:0] in, gnt[1:0] out (one-hot/0).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 = requester 1 was granted last
  logic last;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && req[1]) begin
      gnt = last ? 2'b01 : 2'b10;
    end else if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b0;
    end else if (gnt[1]) begin
      last <= 1'b1;
    end else if (gnt[0]) begin
      last <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Register-bus owner for the PWM block: host byte port + atomic 16-bit
// word writes, round-robin shared. Ports: host_* (byte access),
// wr16_* (word valid/ready), read/write/addr/data_write/data_read
// (register bus), counter_val (sync gate), busy. Define
// PWMSEQ_SYNC_UPDATE_EN to start word writes only at SYNC_VALUE.
module pwm_cfg_sequencer
  import pwm_regs_pkg::*;
#(
  parameter int          ADDR_W     = 6,
  parameter logic [15:0] SYNC_VALUE = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_gnt,
  output logic [7:0]        host_rdata,
  output logic              host_rvalid,
  input  logic              wr16_valid,
  input  logic [ADDR_W-1:0] wr16_addr,
  input  logic [15:0]       wr16_data,
  output logic              wr16_ready,
  output logic              wr16_done,
  output logic              wr16_err,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data_write,
  input  logic [7:0]        data_read,
  input  logic [15:0]       counter_val,
  output logic              busy
);

  seq_state_e        state;
  logic              pending;
  logic [ADDR_W-1:0] w_addr;
  logic [15:0]       w_data;
  logic              h_rd;
  logic              sync_hit;
  logic              gate_open;
  logic              word_legal;
  logic [1:0]        req;
  logic [1:0]        gnt;

  assign sync_hit = (counter_val == SYNC_VALUE);

`ifdef PWMSEQ_SYNC_UPDATE_EN
  assign gate_open = sync_hit;
`else
  // gate held open; the compare term has no effect
  assign gate_open = sync_hit | 1'b1;
`endif

  assign word_legal = is_word_base(32'(wr16_addr));
  assign wr16_ready = !pending;
  assign busy       = (state != ST_IDLE) || pending;

  // arbitration only happens in IDLE
  assign req = {pending && gate_open, host_req}
             & {2{state == ST_IDLE}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pending     <= 1'b0;
      w_addr      <= '0;
      w_data      <= '0;
      h_rd        <= 1'b0;
      read        <= 1'b0;
      write       <= 1'b0;
      addr        <= '0;
      data_write  <= '0;
      host_gnt    <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      wr16_done   <= 1'b0;
      wr16_err    <= 1'b0;
    end else begin
      read        <= 1'b0;
      write       <= 1'b0;
      addr        <= '0;
      data_write  <= '0;
      host_gnt    <= 1'b0;
      host_rvalid <= 1'b0;
      wr16_done   <= 1'b0;
      wr16_err    <= 1'b0;

      // illegal bases never become pending; reject right away
      if (wr16_valid && wr16_ready) begin
        w_addr <= wr16_addr;
        w_data <= wr16_data;
        if (word_legal) begin
          pending <= 1'b1;
        end else begin
          wr16_done <= 1'b1;
          wr16_err  <= 1'b1;
        end
      end

      unique case (state)
        ST_IDLE: begin
          if (gnt[0]) begin
            state      <= ST_HOST;
            h_rd       <= !host_we;
            read       <= !host_we;
            write      <= host_we;
            addr       <= host_addr;
            data_write <= host_we ? host_wdata : 8'h00;
            host_gnt   <= 1'b1;
          end else if (gnt[1]) begin
            state      <= ST_WORD_L;
            write      <= 1'b1;
            addr       <= w_addr;
            data_write <= w_data[7:0];
          end
        end
        ST_HOST: begin
          if (h_rd) begin
            host_rdata  <= data_read;
            host_rvalid <= 1'b1;
          end
          state <= ST_IDLE;
        end
        ST_WORD_L: begin
          state      <= ST_WORD_H;
          write      <= 1'b1;
          addr       <= w_addr + ADDR_W'(1);
          data_write <= w_data[15:8];
        end
        ST_WORD_H: begin
          // freeing the slot now lets a new word be pending by IDLE
          state     <= ST_DONE;
          wr16_done <= 1'b1;
          pending   <= 1'b0;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Self-checking bench for pwm_cfg_sequencer: directed tables,
// corner sequences and a randomized run against a register-map model.
module tb_pwm_cfg_sequencer;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0]    host_wdata = '0;
  logic          host_gnt;
  logic [7:0]    host_rdata;
  logic          host_rvalid;
  logic          wr16_valid = 1'b0;
  logic [AW-1:0] wr16_addr = '0;
  logic [15:0]   wr16_data = '0;
  logic          wr16_ready;
  logic          wr16_done;
  logic          wr16_err;
  logic          read;
  logic          write;
  logic [AW-1:0] addr;
  logic [7:0]    data_write;
  logic [7:0]    data_read;
  logic [15:0]   cnt = '0;
  logic [15:0]   prev_cnt = '0;
  logic [1:0]    cnt_sel = 2'd0;
  logic          busy;

  always #5 clk = ~clk;

  pwm_cfg_sequencer #(.ADDR_W(AW), .SYNC_VALUE(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .wr16_valid  (wr16_valid),
    .wr16_addr   (wr16_addr),
    .wr16_data   (wr16_data),
    .wr16_ready  (wr16_ready),
    .wr16_done   (wr16_done),
    .wr16_err    (wr16_err),
    .read        (read),
    .write       (write),
    .addr        (addr),
    .data_write  (data_write),
    .data_read   (data_read),
    .counter_val (cnt),
    .busy        (busy)
  );

  // register file environment
  logic [7:0] regs [64] = '{default: 8'h00};
  assign data_read = regs[addr];
  always @(posedge clk) if (write) regs[addr] <= data_write;

  // counter: 0 = hold 0, 1 = load 5, 2 = count down (wrap 9)
  always @(posedge clk) begin
    prev_cnt <= cnt;
    case (cnt_sel)
      2'd1:    cnt <= 16'd5;
      2'd2:    cnt <= (cnt == 16'd0) ? 16'd9 : cnt - 16'd1;
      default: cnt <= 16'd0;
    endcase
  end

  int anom = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (read && write) anom++;
      if (!read && !write && (addr != '0 || data_write != 8'h00))
        anom++;
    end
  end

  int n_tot = 0;
  int n_pass = 0;

  // reference register map
  logic [7:0] mem [64];
  bit         known [64];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal_base(input logic [AW-1:0] a);
    return (a == 6'h00) || (a == 6'h03) || (a == 6'h05);
  endfunction

  task automatic host_op(input logic we, input logic [AW-1:0] a,
                         input logic [7:0] d, output logic [7:0] rd);
    int lat;
    rd = 8'h00;
    host_we = we;
    host_addr = a;
    host_wdata = d;
    host_req = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!host_gnt && lat < 20);
    host_req = 1'b0;
    chk("host_gnt_latency", lat, 1);
    if (!host_gnt) return;
    chk("host_strobe", {read, write, addr, data_write},
        {!we, we, a, (we ? d : 8'h00)});
    tick();
    chk("host_rvalid", host_rvalid, !we);
    rd = host_rdata;
    if (we) begin
      mem[a] = d;
      known[a] = 1'b1;
    end
  endtask

  task automatic word_op(input logic [AW-1:0] a, input logic [15:0] d);
    int w;
    w = 0;
    while (!wr16_ready && w < 20) begin
      tick();
      w++;
    end
    chk("wr16_ready_wait", wr16_ready, 1);
    wr16_addr = a;
    wr16_data = d;
    wr16_valid = 1'b1;
    tick();
    wr16_valid = 1'b0;
    if (!legal_base(a)) begin
      chk("illegal_done", {wr16_done, wr16_err, read, write}, 4'b1100);
      tick();
      chk("illegal_done_once", wr16_done, 0);
    end else begin
      chk("word_accept", {wr16_ready, busy, write, wr16_done}, 4'b0100);
      tick();
      chk("word_l", {write, read, host_gnt, addr, data_write},
          {3'b100, a, d[7:0]});
      tick();
      chk("word_h", {write, read, host_gnt, addr, data_write},
          {3'b100, a + 6'd1, d[15:8]});
      tick();
      chk("word_done", {wr16_done, wr16_err, write}, 3'b100);
      tick();
      mem[a] = d[7:0];
      mem[a + 6'd1] = d[15:8];
      known[a] = 1'b1;
      known[a + 6'd1] = 1'b1;
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic [7:0]    exp;
  } hv_t;

  hv_t tbl [6];

  initial begin
    logic [7:0] rd;
    int ev [$];
    bit re;
    int errs;

    tbl[0] = '{1'b1, 6'h0A, 8'h04, 8'h00};
    tbl[1] = '{1'b0, 6'h0A, 8'h00, 8'h04};
    tbl[2] = '{1'b1, 6'h01, 8'hA5, 8'h00};
    tbl[3] = '{1'b0, 6'h01, 8'h00, 8'hA5};
    tbl[4] = '{1'b1, 6'h3F, 8'h5A, 8'h00};
    tbl[5] = '{1'b0, 6'h3F, 8'h00, 8'h5A};
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'h00;
      known[i] = 1'b0;
    end

    // reset state
    repeat (3) tick();
    chk("reset_ready", wr16_ready, 1);
    chk("reset_outputs",
        {host_gnt, host_rdata, host_rvalid, wr16_done, wr16_err,
         read, write, addr, data_write, busy}, 0);
    rst_n = 1'b1;
    tick();

    // host table
    for (int i = 0; i < 6; i++) begin
      host_op(tbl[i].we, tbl[i].a, tbl[i].d, rd);
      if (!tbl[i].we) chk("tbl_rdata", rd, tbl[i].exp);
    end

    // word write and illegal word
    word_op(6'h03, 16'h1234);
    chk("word_regs", {regs[3], regs[4]}, 16'h3412);
    word_op(6'h07, 16'hFFFF);
    chk("illegal_no_write", {regs[7], regs[8]}, 16'h0000);

    // reset during WORD_H
    wr16_addr = 6'h05;
    wr16_data = 16'hABCD;
    wr16_valid = 1'b1;
    tick();
    wr16_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset_word_h", {write, addr, data_write}, {1'b1, 6'h06, 8'hAB});
    rst_n = 1'b0;
    tick();
    chk("reset_mid_word",
        {wr16_ready, wr16_done, busy, read, write, addr, data_write},
        {1'b1, 18'h0});
    rst_n = 1'b1;
    tick();
    chk("reset_no_done", {wr16_done, busy, write}, 3'b000);

    // continuous contention right after reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wr16_addr = 6'h05;
    wr16_data = 16'h55AA;
    wr16_valid = 1'b1;
    tick();
    host_we = 1'b0;
    host_addr = 6'h02;
    host_req = 1'b1;
    re = 1'b0;
    for (int c = 0; c < 80 && ev.size() < 8; c++) begin
      tick();
      if (re) begin
        host_req = 1'b1;
        re = 1'b0;
      end
      if (host_gnt) begin
        ev.push_back(2);
        host_req = 1'b0;
        re = 1'b1;
      end
      if (write && addr == 6'h05) begin
        ev.push_back(1);
        tick();
        chk("word_atomic", {write, host_gnt, addr}, {2'b10, 6'h06});
      end
    end
    wr16_valid = 1'b0;
    host_req = 1'b0;
    chk("arb_count", ev.size(), 8);
    for (int i = 0; i < ev.size(); i++)
      chk("arb_order", ev[i], (i % 2 == 0) ? 1 : 2);
    repeat (8) tick();

`ifdef PWMSEQ_SYNC_UPDATE_EN
    // sync gate: word waits for counter 0, host proceeds
    cnt_sel = 2'd1;
    tick();
    cnt_sel = 2'd2;
    wr16_addr = 6'h00;
    wr16_data = 16'hBEEF;
    wr16_valid = 1'b1;
    tick();
    wr16_valid = 1'b0;
    host_op(1'b0, 6'h0A, 8'h00, rd);
    chk("sync_host_rdata", rd, 8'h04);
    begin
      int w;
      w = 0;
      while (!(write && addr == 6'h00) && w < 30) begin
        tick();
        w++;
      end
    end
    chk("sync_word_l", {write, data_write}, {1'b1, 8'hEF});
    chk("sync_prev_cnt", prev_cnt, 0);
    tick();
    tick();
    chk("sync_done", {wr16_done, wr16_err}, 2'b10);
    cnt_sel = 2'd0;
    repeat (2) tick();
`endif

    // randomized transactions against the map model
    for (int i = 0; i < 64; i++) known[i] = 1'b0;
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      int unsigned   k;
      k = $urandom_range(0, 2);
      if (k == 0) begin
        a = 6'($urandom_range(0, 7));
        host_op(1'b1, a, 8'($urandom), rd);
      end else if (k == 1) begin
        a = 6'($urandom_range(0, 7));
        host_op(1'b0, a, 8'h00, rd);
        if (known[a]) chk("rand_rdata", rd, mem[a]);
      end else begin
        if ($urandom_range(0, 3) != 0) begin
          k = $urandom_range(0, 2);
          a = (k == 0) ? 6'h00 : (k == 1) ? 6'h03 : 6'h05;
        end else begin
          a = 6'($urandom_range(0, 63));
        end
        word_op(a, 16'($urandom));
      end
    end
    errs = 0;
    for (int i = 0; i < 64; i++)
      if (known[i] && regs[i] != mem[i]) errs++;
    chk("rand_regfile", errs, 0);
    chk("bus_anomalies", anom, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
